nhan_cong_tuantu: RTL and testbench
===================================

# nhan_cong_tuantu

- Sequential multiply-add unit: computes P = A·B + C·D (unsigned, 4-bit operands, 9-bit result).
- Uses one shared 4×4 unsigned multiplier and one 8-bit adder, time-multiplexed over two cycles, instead of two multipliers.
- Sits where area matters more than latency.
- Operands in and the result out each use a request/acknowledge handshake, so it can sit between a producer and a consumer that stall.

## Interface
Parameters: none. Widths are fixed by the operand format.

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  operand request; qualified by ready
- A  input  4  unsigned operand, multiplied by B
- B  input  4  unsigned operand
- C  input  4  unsigned operand, multiplied by D
- D  input  4  unsigned operand
- ready  output  1  block accepts start this cycle (combinational)
- valid  output  1  P holds a completed result
- ack  input  1  consumer takes result; qualified by valid
- P  output  9  registered result A·B + C·D

## Operation
- Only one clock and one asynchronous active-low reset; no other reset path.
- FSM states:
  - IDLE: ready=1, valid=0.
  - MUL1: apply latched A,B to the shared multiplier; accumulator <= A·B (zero-extended to 9 bits).
  - MUL2: apply latched C,D to the shared multiplier; P <= accumulator + C·D (8-bit + 8-bit, carry into bit 8).
  - HOLD: valid=1.
- ready = (state==IDLE) | (state==HOLD & ack).
- Accept = start & ready. On accept, A,B,C,D are captured into operand registers and the next state is MUL1. Input operands are don't-care after the accept edge.
- Transitions:
  - IDLE → MUL1 on accept; otherwise stay in IDLE.
  - MUL1 → MUL2 unconditionally.
  - MUL2 → HOLD unconditionally.
  - HOLD with ack=0: stay in HOLD; P and valid are held stable.
  - HOLD with ack=1 and start=0: → IDLE.
  - HOLD with ack=1 and start=1: back-to-back. The new operands are latched and the next state is MUL1; valid drops.
- start while in MUL1 or MUL2 is ignored: not queued, and operands are not re-latched.
- ack outside HOLD is ignored.
- P is written only on the MUL2 → HOLD edge. It keeps the last result in IDLE, MUL1 and MUL2 until the next result overwrites it.
- Arithmetic:
  - Unsigned throughout; no overflow is possible.
  - Maximum value 15·15 + 15·15 = 450 < 512.
  - The multiplier output is 8 bits; the adder carry-out is P[8].
- Reset, at any time including mid-operation:
  - Asynchronously forces IDLE.
  - valid=0, P=0; accumulator and operand registers = 0.
  - ready=1 once reset is released.
  - Any in-flight computation is discarded.

## Timing
- Accept on edge k → MUL1 during k..k+1 → MUL2 during k+1..k+2 → valid=1 and P correct from edge k+2.
- Latency is 2 clocks from the accept edge to valid.
- Minimum initiation interval is 3 clocks when ack is held high: accept, MUL1, MUL2, then HOLD with ack+start re-accepting.
- valid falls on the edge where ack is sampled in HOLD.
- ready is combinational from state and ack. No combinational path exists from start to valid or to P.
- Values after reset: ready=1, valid=0, P=9'd0.

## Test plan
- Basic: A=12,B=2,C=10,D=3, start pulsed while ready, ack=1 → valid rises exactly 2 cycles after the accept edge with P=54; returns to IDLE next cycle.
- Maximum: A=B=C=D=15 → P=450 (9'h1C2); P[8]=1.
- Stall: A=12,B=6,C=11,D=15, ack=0 for 5 cycles after valid:
  - valid stays 1 and P stays 237 throughout.
  - ready stays 0 throughout.
  - Raising ack → valid=0 on the next edge.
- Ignore while busy:
  - Accept A=7,B=7,C=8,D=3.
  - Assert start with A=14,B=5,C=5,D=9 during MUL1 and MUL2.
  - Required: result P=73, and no second computation starts.
- Back-to-back:
  - In HOLD with P=73, assert ack=1 and start=1 together with A=14,B=5,C=5,D=9.
  - valid drops for 2 cycles, then valid=1 with P=115.
  - Next job A=7,B=2,C=10,D=8 → P=94.
- Reset mid-operation:
  - Drive rst_n=0 during MUL2 of A=4,B=6,C=15,D=10.
  - Immediately: valid=0, P=0, state IDLE.
  - After release, a new job A=4,B=6,C=15,D=10 → P=174.

Source files
------------

// File: rtl/nhan_cong_tuantu.sv
// Sequential multiply-add P = A*B + C*D using one shared 4x4 multiplier over two cycles,
// with request/acknowledge handshakes on both the operand and the result side.
module nhan_cong_tuantu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    output logic       ready,
    output logic       valid,
    input  logic       ack,
    output logic [8:0] P
);

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, HOLD} state_t;

    state_t     state;
    logic [3:0] a_q, b_q, c_q, d_q;
    logic [8:0] acc;
    logic [3:0] mul_x, mul_y;
    logic [7:0] product;
    logic [8:0] sum;
    logic       accept;

    assign ready  = (state == IDLE) | ((state == HOLD) & ack);
    assign accept = start & ready;

    // The single multiplier sees A,B in MUL1 and C,D in MUL2.
    always_comb begin
        mul_x = a_q;
        mul_y = b_q;
        if (state == MUL2) begin
            mul_x = c_q;
            mul_y = d_q;
        end
    end

    assign product = mul_x * mul_y;
    assign sum     = acc + {1'b0, product};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            c_q   <= 4'd0;
            d_q   <= 4'd0;
            acc   <= 9'd0;
            P     <= 9'd0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= A;
                        b_q   <= B;
                        c_q   <= C;
                        d_q   <= D;
                        state <= MUL1;
                    end
                end
                MUL1: begin
                    acc   <= {1'b0, product};
                    state <= MUL2;
                end
                MUL2: begin
                    P     <= sum;
                    valid <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    // Result leaves on ack; a simultaneous start re-launches without an idle cycle.
                    if (ack) begin
                        valid <= 1'b0;
                        if (start) begin
                            a_q   <= A;
                            b_q   <= B;
                            c_q   <= C;
                            d_q   <= D;
                            state <= MUL1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nhan_cong_tuantu.sv
// Directed testbench for nhan_cong_tuantu: table of jobs plus hand-written stall,
// busy-ignore, back-to-back and mid-operation reset sequences.
module tb_nhan_cong_tuantu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ack;
    logic [3:0] A, B, C, D;
    logic       ready;
    logic       valid;
    logic [8:0] P;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        int         p;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    nhan_cong_tuantu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .ready (ready),
        .valid (valid),
        .ack   (ack),
        .P     (P)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic setOperands(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d);
        A = a;
        B = b;
        C = c;
        D = d;
    endtask

    // Called at a negedge with the block idle; returns at the negedge where valid is first seen.
    task automatic applyStimulus(input vec_t v, output int latency);
        setOperands(v.a, v.b, v.c, v.d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        setOperands(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        latency = -1;
        for (int i = 0; i < 10; i++) begin
            if (valid) begin
                latency = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{a: 4'd12, b: 4'd2,  c: 4'd10, d: 4'd3,  p: 54};
        vecs[1] = '{a: 4'd15, b: 4'd15, c: 4'd15, d: 4'd15, p: 450};
        vecs[2] = '{a: 4'd12, b: 4'd6,  c: 4'd11, d: 4'd15, p: 237};
        vecs[3] = '{a: 4'd7,  b: 4'd7,  c: 4'd8,  d: 4'd3,  p: 73};
        vecs[4] = '{a: 4'd14, b: 4'd5,  c: 4'd5,  d: 4'd9,  p: 115};
        vecs[5] = '{a: 4'd7,  b: 4'd2,  c: 4'd10, d: 4'd8,  p: 94};
        vecs[6] = '{a: 4'd4,  b: 4'd6,  c: 4'd15, d: 4'd10, p: 174};
        vecs[7] = '{a: 4'd0,  b: 4'd0,  c: 4'd0,  d: 4'd0,  p: 0};
        vecs[8] = '{a: 4'd1,  b: 4'd15, c: 4'd15, d: 4'd1,  p: 30};

        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        setOperands(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset ready", int'(ready), 1);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset P", int'(P), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset ready", int'(ready), 1);

        // Table: ack held high, so each result is taken in its single HOLD cycle.
        ack = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("vec%0d latency", i), lat, 2);
            checkOutput($sformatf("vec%0d P", i), int'(P), vecs[i].p);
            if (i == 1) checkOutput("max P[8]", int'(P[8]), 1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d valid drop", i), int'(valid), 0);
            checkOutput($sformatf("vec%0d idle ready", i), int'(ready), 1);
        end

        // Stall: consumer holds off for 5 cycles.
        ack = 1'b0;
        applyStimulus(vecs[2], lat);
        checkOutput("stall latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall valid %0d", i), int'(valid), 1);
            checkOutput($sformatf("stall P %0d", i), int'(P), 237);
            checkOutput($sformatf("stall ready %0d", i), int'(ready), 0);
            @(negedge clk);
        end
        ack = 1'b1;
        #1;
        checkOutput("stall ready on ack", int'(ready), 1);
        @(negedge clk);
        checkOutput("stall valid after ack", int'(valid), 0);
        ack = 1'b0;

        // Busy: start held through MUL1 and MUL2 with different operands.
        setOperands(4'd7, 4'd7, 4'd8, 4'd3);
        start = 1'b1;
        @(negedge clk);
        setOperands(4'd14, 4'd5, 4'd5, 4'd9);
        checkOutput("busy ready MUL1", int'(ready), 0);
        @(negedge clk);
        checkOutput("busy ready MUL2", int'(ready), 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy valid", int'(valid), 1);
        checkOutput("busy P", int'(P), 73);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("busy hold valid %0d", i), int'(valid), 1);
            checkOutput($sformatf("busy hold P %0d", i), int'(P), 73);
        end

        // Back-to-back: ack and start together in HOLD.
        setOperands(4'd14, 4'd5, 4'd5, 4'd9);
        start = 1'b1;
        ack   = 1'b1;
        #1;
        checkOutput("b2b ready", int'(ready), 1);
        @(negedge clk);
        start = 1'b0;
        setOperands(4'd3, 4'd3, 4'd3, 4'd3);
        checkOutput("b2b valid c1", int'(valid), 0);
        @(negedge clk);
        checkOutput("b2b valid c2", int'(valid), 0);
        @(negedge clk);
        checkOutput("b2b valid", int'(valid), 1);
        checkOutput("b2b P", int'(P), 115);
        setOperands(4'd7, 4'd2, 4'd10, 4'd8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b2 valid c1", int'(valid), 0);
        @(negedge clk);
        checkOutput("b2b2 valid c2", int'(valid), 0);
        @(negedge clk);
        checkOutput("b2b2 valid", int'(valid), 1);
        checkOutput("b2b2 P", int'(P), 94);
        @(negedge clk);
        checkOutput("b2b2 idle", int'(ready), 1);

        // Reset during MUL2 discards the job and clears P at once.
        ack = 1'b0;
        setOperands(4'd4, 4'd6, 4'd15, 4'd10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst mid valid", int'(valid), 0);
        checkOutput("rst mid P", int'(P), 0);
        checkOutput("rst mid ready", int'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst after valid", int'(valid), 0);
        ack = 1'b1;
        applyStimulus(vecs[6], lat);
        checkOutput("rst job latency", lat, 2);
        checkOutput("rst job P", int'(P), 174);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
